// File: rtl/keccak_share_pkg.sv
// Shared types and default widths for the Keccak front-end sharing controller.
package keccak_share_pkg;

   localparam int KS_W   = 192;
   localparam int KS_DW  = 512;
   localparam int KS_BNW = 6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_STREAM  = 3'd2,
      ST_WAIT    = 3'd3,
      ST_DELIVER = 3'd4
   } ks_state_e;

endpackage

// File: rtl/keccak_share_ctrl_rr_arbiter.sv
// Round-robin pick: first requester with req=1 at or after i_ptr, modulo N_REQ.
module rr_arbiter #(
   parameter int N_REQ = 3,
   parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [PW-1:0]    i_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic [PW-1:0]    o_idx,
   output logic             o_valid
);

   logic [PW:0] w_sum;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_sum   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_sum = {1'b0, i_ptr} + (PW+1)'(i);
         if (w_sum >= (PW+1)'(N_REQ))
            w_sum = w_sum - (PW+1)'(N_REQ);
         if (!o_valid && i_req[w_sum[PW-1:0]]) begin
            o_valid                 = 1'b1;
            o_idx                   = w_sum[PW-1:0];
            o_grant[w_sum[PW-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/keccak_share_ctrl.sv
// Shares one padder + f_permutation between N_REQ hash users; pulses a core
// reset before each message, streams the owner's words, returns the digest.
module keccak_share_ctrl
   import keccak_share_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int W     = KS_W,
   parameter int BNW   = KS_BNW,
   parameter int DW    = KS_DW
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [N_REQ-1:0]     i_req,
   input  logic [N_REQ*W-1:0]   i_req_in,
   input  logic [N_REQ-1:0]     i_req_in_ready,
   input  logic [N_REQ-1:0]     i_req_is_last,
   input  logic [N_REQ*BNW-1:0] i_req_byte_num,
   output logic [N_REQ-1:0]     o_grant,
   output logic [N_REQ-1:0]     o_req_buffer_full,
   output logic [N_REQ-1:0]     o_out_valid,
   output logic [DW-1:0]        o_out_data,
   output logic                 o_core_reset,
   output logic [W-1:0]         o_core_in,
   output logic                 o_core_in_ready,
   output logic                 o_core_is_last,
   output logic [BNW-1:0]       o_core_byte_num,
   input  logic                 i_core_buffer_full,
   input  logic [DW-1:0]        i_core_out,
   input  logic                 i_core_out_ready
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   ks_state_e          r_state, w_state_nxt;
   logic [N_REQ-1:0]   r_grant, r_out_valid;
   logic [PW-1:0]      r_owner, r_ptr, w_ptr_inc;
   logic [DW-1:0]      r_out_data;

   logic [N_REQ-1:0]   w_arb_grant;
   logic [PW-1:0]      w_arb_idx;
   logic               w_arb_valid;

   logic               w_own_req, w_own_rdy, w_own_last, w_last_acc, w_stream, w_to_idle;
   logic [W-1:0]       w_own_word;
   logic [BNW-1:0]     w_own_bn;

   rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   assign w_own_req  = i_req[r_owner];
   assign w_own_rdy  = i_req_in_ready[r_owner];
   assign w_own_last = i_req_is_last[r_owner];
   assign w_own_word = i_req_in[r_owner*W +: W];
   assign w_own_bn   = i_req_byte_num[r_owner*BNW +: BNW];
   assign w_last_acc = w_own_rdy & w_own_last & ~i_core_buffer_full;
   assign w_stream   = (r_state == ST_STREAM);
   assign w_ptr_inc  = (r_owner == PW'(N_REQ-1)) ? '0 : r_owner + PW'(1);

   // A dropped req in STREAM/WAIT aborts, and beats a same-cycle is_last.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_arb_valid) w_state_nxt = ST_CLEAR;
         ST_CLEAR:   w_state_nxt = ST_STREAM;
         ST_STREAM:  if (!w_own_req) w_state_nxt = ST_IDLE;
                     else if (w_last_acc) w_state_nxt = ST_WAIT;
         ST_WAIT:    if (!w_own_req) w_state_nxt = ST_IDLE;
                     else if (i_core_out_ready) w_state_nxt = ST_DELIVER;
         ST_DELIVER: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_to_idle = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_grant     <= '0;
         r_owner     <= '0;
         r_ptr       <= '0;
         r_out_data  <= '0;
         r_out_valid <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= (r_state == ST_DELIVER) ? r_grant : '0;
         if (r_state == ST_IDLE && w_arb_valid) begin
            r_grant <= w_arb_grant;
            r_owner <= w_arb_idx;
         end
         if (w_to_idle) begin
            r_grant <= '0;
            r_ptr   <= w_ptr_inc;
         end
         if (r_state == ST_WAIT && w_state_nxt == ST_DELIVER)
            r_out_data <= i_core_out;
      end
   end

   assign o_grant           = r_grant;
   assign o_out_valid       = r_out_valid;
   assign o_out_data        = r_out_data;
   assign o_req_buffer_full = ~r_grant | (r_grant & {N_REQ{i_core_buffer_full}});
   assign o_core_reset      = i_reset | (r_state == ST_CLEAR);
   assign o_core_in         = w_stream ? w_own_word : '0;
   assign o_core_in_ready   = w_stream & w_own_rdy;
   assign o_core_is_last    = w_stream & w_own_last;
   assign o_core_byte_num   = w_stream ? w_own_bn : '0;

endmodule

// File: doc/keccak_share_ctrl.md
# keccak_share_ctrl

Round-robin controller that shares one Keccak front end (padder + f_permutation, 192-bit input words, 512-bit digest) between up to N_REQ hash requesters, e.g. hash_h, hash_g and PRF. The padder's `state` and `done` flags clear only on reset, so the controller pulses a dedicated core reset before every message. It then streams the granted requester's words into the padder, waits for the digest, and returns the digest to that requester. It sits between the Kyber hash users and the single shared Keccak instance.

## Interface
- N_REQ, 3, number of requesters (2..8)
- W, 192, input word width
- BNW, 6, byte_num width
- DW, 512, digest width
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req  in  N_REQ  per-requester request; held from assertion until its out_valid bit, or dropped to abort
- req_in  in  N_REQ*W  packed words; requester k occupies bits [k*W +: W]
- req_in_ready  in  N_REQ  word valid, per requester
- req_is_last  in  N_REQ  last word of message, per requester
- req_byte_num  in  N_REQ*BNW  valid bytes in the last word, packed like req_in
- grant  out  N_REQ  one-hot owner, or zero
- req_buffer_full  out  N_REQ  core_buffer_full routed to the owner only; 1 for every non-owner
- out_valid  out  N_REQ  one-cycle, one-hot digest strobe
- out_data  out  DW  registered digest
- core_reset  out  1  reset to padder/f_permutation
- core_in  out  W  word to padder
- core_in_ready, core_is_last  out  1  to padder
- core_byte_num  out  BNW  to padder
- core_buffer_full  in  1  from padder
- core_out  in  DW  digest from f_permutation
- core_out_ready  in  1  digest valid; stays high until core_reset

## Operation
- FSM states:
  - IDLE: no owner.
  - CLEAR: core_reset=1 for exactly 1 cycle.
  - STREAM: core_* ports muxed from the owner.
  - WAIT: stop feeding; wait for the digest.
  - DELIVER: latch core_out into out_data; pulse out_valid[owner].
- Transitions:
  - IDLE→CLEAR when any req is high. The winner is the first requester with req=1 at or after rr_ptr, modulo N_REQ. grant becomes one-hot on the transition edge and holds until the owner returns to IDLE.
  - CLEAR→STREAM unconditionally.
  - STREAM→WAIT when the owner's is_last is accepted. Accepted means req_in_ready[o] & req_is_last[o] & ~core_buffer_full.
  - WAIT→DELIVER when core_out_ready=1.
  - DELIVER→IDLE unconditionally. rr_ptr ← (owner+1) mod N_REQ.
- Abort: if req[o]=0 in STREAM or WAIT, go to IDLE. No out_valid is issued and rr_ptr still advances. The next grant passes through CLEAR, which purges any partial core state.
- Muxing outside STREAM: core_in_ready=0, core_is_last=0, core_in=0, core_byte_num=0.
- Inside STREAM, core_in_ready and core_is_last are forwarded combinationally from the owner. The requester sees backpressure through req_buffer_full[o]. No internal word buffering.
- out_data holds its value until the next DELIVER.

## Timing
- During reset and on the cycle after it: state=IDLE, grant=0, out_valid=0, out_data=0, rr_ptr=0.
- core_reset = reset | (state==CLEAR), so it is 1 while reset is high.
- Arbitration latency: req rises in cycle t → grant set at t+1, core_reset high in t+1, first word may be accepted in t+2.
- Digest latency: core_out_ready high in cycle t → out_valid and out_data valid in t+2. The digest is latched on entering DELIVER.
- Simultaneous requests resolve in round-robin order; no requester waits more than N_REQ-1 messages.
- is_last accepted in the same cycle as req drop: the abort wins.
- req rising during CLEAR/STREAM/WAIT/DELIVER is ignored until IDLE. Minimum gap between grants is 1 IDLE cycle.
- Reset mid-message returns to IDLE immediately; all outputs are at reset values in the next cycle.

## Structure
- Shared package keccak_share_pkg holds:
  - FSM state enum (IDLE, CLEAR, STREAM, WAIT, DELIVER)
  - default W, DW and BNW constants
- One sub-module, rr_arbiter: N_REQ round-robin pick from req and rr_ptr, giving a one-hot winner and a valid flag.
- Everything else stays in keccak_share_ctrl: FSM, muxes and digest register.

## Test plan
- Single requester: reset; req[0]=1 with 3 words, last word byte_num=5 → grant=001 at t+1, one core_reset pulse, 3 core_in_ready beats, out_valid=001 with out_data = model digest 2 cycles after core_out_ready.
- Contention: req=111 held simultaneously, rr_ptr=0 → service order 0,1,2; then req=101 → order 0,2; each message preceded by exactly one core_reset pulse.
- Backpressure: core_buffer_full high for 4 cycles mid-stream → req_buffer_full[o]=1, no word lost or duplicated, and is_last is not accepted while full.
- Abort: owner 1 drops req after 2 words → state returns to IDLE, no out_valid, rr_ptr=2, next grant goes through CLEAR and its digest matches the model.
- Reset mid-WAIT → grant=0, out_valid=0, out_data=0, core_reset=1 during reset; a new message afterwards completes correctly.
- Non-owners: req_in_ready[2] toggling while 0 owns the core → no core_in_ready effect, and req_buffer_full[2]=1 throughout.
